// File: rtl/midi_pkg.sv
// Shared MIDI parsing definitions: status type codes, byte-class thresholds
// and the parser state encoding.
package midi_pkg;

    localparam logic [3:0] NOTE_OFF = 4'h8;
    localparam logic [3:0] NOTE_ON  = 4'h9;
    localparam logic [3:0] PROG_CHG = 4'hC;
    localparam logic [3:0] CH_PRESS = 4'hD;

    // Bytes at or above these values are system common / real-time.
    localparam logic [7:0] SYS_COMMON_MIN = 8'hF0;
    localparam logic [7:0] REALTIME_MIN   = 8'hF8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA1 = 2'd1,
        DATA2 = 2'd2
    } midi_state_e;

    function automatic logic is_one_data_type(input logic [3:0] status);
        return (status == PROG_CHG) || (status == CH_PRESS);
    endfunction

endpackage

// File: rtl/midi_note_ctrl.sv
// Monophonic MIDI Note-On/Note-Off parser with running status driving the
// oscillator note, gate and phase-reset inputs.
module midi_note_ctrl
    import midi_pkg::*;
#(
    parameter logic [3:0] CHANNEL    = 4'd0,
    parameter logic [7:0] RESET_NOTE = 8'd69
) (
    input  logic       clk_i,
    input  logic       nrst_i,
    input  logic [7:0] rxData_i,
    input  logic       rxValid_i,
    output logic [7:0] note_o,
    output logic       gate_o,
    output logic       nrstPhase_o
);

    // Input capture stage: a byte sampled on one edge acts on the next edge.
    logic [7:0]  byte_reg;
    logic        valid_reg;

    midi_state_e state_reg, state_next;
    logic [3:0]  status_reg, status_next;
    logic        ch_match_reg, ch_match_next;
    logic [6:0]  data1_reg, data1_next;
    logic [7:0]  note_reg, note_next;
    logic        gate_reg, gate_next;
    logic        phase_reg, phase_next;

    logic        msg_done;
    logic [6:0]  msg_key;
    logic [6:0]  msg_vel;

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            byte_reg     <= 8'h00;
            valid_reg    <= 1'b0;
            state_reg    <= IDLE;
            status_reg   <= 4'h0;
            ch_match_reg <= 1'b0;
            data1_reg    <= 7'h00;
            note_reg     <= RESET_NOTE;
            gate_reg     <= 1'b0;
            phase_reg    <= 1'b0;
        end else begin
            byte_reg     <= rxData_i;
            valid_reg    <= rxValid_i;
            state_reg    <= state_next;
            status_reg   <= status_next;
            ch_match_reg <= ch_match_next;
            data1_reg    <= data1_next;
            note_reg     <= note_next;
            gate_reg     <= gate_next;
            phase_reg    <= phase_next;
        end
    end

    // Framing: decide the next parser state and whether a message completes.
    always_comb begin
        state_next    = state_reg;
        status_next   = status_reg;
        ch_match_next = ch_match_reg;
        data1_next    = data1_reg;
        msg_done      = 1'b0;
        msg_key       = data1_reg;
        msg_vel       = byte_reg[6:0];

        if (valid_reg) begin
            if (byte_reg >= REALTIME_MIN) begin
                state_next = state_reg;
            end else if (byte_reg >= SYS_COMMON_MIN) begin
                state_next = IDLE;
            end else if (byte_reg[7]) begin
                status_next   = byte_reg[7:4];
                ch_match_next = (byte_reg[3:0] == CHANNEL);
                state_next    = DATA1;
            end else begin
                case (state_reg)
                    DATA1: begin
                        if (is_one_data_type(status_reg)) begin
                            msg_done = 1'b1;
                            msg_key  = byte_reg[6:0];
                        end else begin
                            data1_next = byte_reg[6:0];
                            state_next = DATA2;
                        end
                    end
                    DATA2: begin
                        msg_done   = 1'b1;
                        state_next = DATA1;
                    end
                    default: state_next = IDLE;
                endcase
            end
        end
    end

    always_comb begin
        note_next  = note_reg;
        gate_next  = gate_reg;
        phase_next = 1'b0;

        if (msg_done && ch_match_reg) begin
            if (status_reg == NOTE_ON && msg_vel != 7'd0) begin
                note_next  = {1'b0, msg_key};
                gate_next  = 1'b1;
                phase_next = 1'b1;
            end else if (status_reg == NOTE_OFF || status_reg == NOTE_ON) begin
                // Only releasing the sounding note closes the gate.
                if (gate_reg && ({1'b0, msg_key} == note_reg))
                    gate_next = 1'b0;
            end
        end
    end

    assign note_o      = note_reg;
    assign gate_o      = gate_reg;
    assign nrstPhase_o = phase_reg;

endmodule

// File: tb/tb_midi_note_ctrl.sv
// Scoreboard bench for midi_note_ctrl: a behavioural model predicts outputs
// per driven cycle; predictions are compared when the DUT output is due.
module tb_midi_note_ctrl;

    logic       clk_i = 1'b0;
    logic       nrst_i;
    logic [7:0] rxData_i;
    logic       rxValid_i;
    logic [7:0] note_o;
    logic       gate_o;
    logic       nrstPhase_o;

    int compared   = 0;
    int mismatched = 0;

    typedef struct packed {
        logic [7:0] note;
        logic       gate;
        logic       phase;
    } exp_t;

    exp_t exp_q[$];

    // Behavioural reference model
    int         m_state;   // 0 idle, 1 first data, 2 second data
    logic [3:0] m_status;
    logic       m_ch;
    logic [6:0] m_d1;
    logic [7:0] e_note;
    logic       e_gate;
    logic       e_phase;

    midi_note_ctrl #(.CHANNEL(4'd0), .RESET_NOTE(8'd69)) dut (
        .clk_i      (clk_i),
        .nrst_i     (nrst_i),
        .rxData_i   (rxData_i),
        .rxValid_i  (rxValid_i),
        .note_o     (note_o),
        .gate_o     (gate_o),
        .nrstPhase_o(nrstPhase_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state  = 0;
        m_status = 4'h0;
        m_ch     = 1'b0;
        m_d1     = 7'h00;
        e_note   = 8'd69;
        e_gate   = 1'b0;
        e_phase  = 1'b0;
    endtask

    task automatic model_complete(input logic [6:0] key, input logic [6:0] vel);
        if (!m_ch) return;
        if (m_status == 4'h9 && vel != 0) begin
            e_note  = {1'b0, key};
            e_gate  = 1'b1;
            e_phase = 1'b1;
        end else if (m_status == 4'h8 || m_status == 4'h9) begin
            if (e_gate && e_note == {1'b0, key}) e_gate = 1'b0;
        end
    endtask

    task automatic model_cycle(input logic valid, input logic [7:0] b);
        e_phase = 1'b0;
        if (!valid) return;
        if (b >= 8'hF8) begin
            // real-time: transparent
        end else if (b >= 8'hF0) begin
            m_state = 0;
        end else if (b[7]) begin
            m_status = b[7:4];
            m_ch     = (b[3:0] == 4'd0);
            m_state  = 1;
        end else if (m_state == 1) begin
            if (m_status == 4'hC || m_status == 4'hD) model_complete(b[6:0], 7'd0);
            else begin
                m_d1    = b[6:0];
                m_state = 2;
            end
        end else if (m_state == 2) begin
            model_complete(m_d1, b[6:0]);
            m_state = 1;
        end
    endtask

    // One clock cycle of stimulus; the prediction for the byte driven in the
    // previous cycle is due after this edge.
    task automatic cycle(input logic valid, input logic [7:0] b);
        exp_t e;
        @(negedge clk_i);
        rxValid_i = valid;
        rxData_i  = valid ? b : 8'h00;
        model_cycle(valid, b);
        exp_q.push_back({e_note, e_gate, e_phase});
        @(posedge clk_i);
        #1;
        if (exp_q.size() > 1) begin
            e = exp_q.pop_front();
            check_eq($sformatf("note b=%02h", b), note_o, e.note);
            check_eq($sformatf("gate b=%02h", b), gate_o, e.gate);
            check_eq($sformatf("phase b=%02h", b), nrstPhase_o, e.phase);
        end
    endtask

    task automatic send(input logic [7:0] b);
        cycle(1'b1, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
    endtask

    task automatic send_list(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send(bytes[i]);
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk_i);
        rxValid_i = 1'b0;
        rxData_i  = 8'h00;
        nrst_i    = 1'b0;
        #1;
        check_eq({tag, " note"}, note_o, 8'd69);
        check_eq({tag, " gate"}, gate_o, 1'b0);
        check_eq({tag, " phase"}, nrstPhase_o, 1'b0);
        exp_q.delete();
        model_reset();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        nrst_i = 1'b1;
    endtask

    initial begin
        nrst_i    = 1'b1;
        rxValid_i = 1'b0;
        rxData_i  = 8'h00;
        model_reset();
        #2;
        apply_reset("reset");

        // Basic Note-On, pulse lasts exactly one cycle
        send_list('{8'h90, 8'h3C, 8'h64});
        idle(3);

        // Running-status retrigger then velocity-0 release
        send_list('{8'h40, 8'h50});
        idle(2);
        send_list('{8'h40, 8'h00});
        idle(2);

        // Note-Off mismatch keeps gate, matching note releases it
        send_list('{8'h90, 8'h40, 8'h10, 8'h80, 8'h3C, 8'h00});
        idle(1);
        send_list('{8'h80, 8'h40, 8'h00});
        idle(2);

        // Channel filter and foreign traffic
        send_list('{8'h91, 8'h3C, 8'h64});
        send_list('{8'hC0, 8'h05, 8'h05});
        send_list('{8'hB0, 8'h07, 8'h7F});
        send_list('{8'h90, 8'h30, 8'h10});
        idle(2);
        send_list('{8'h80, 8'h30, 8'h00});

        // Real-time bytes interleaved, then system common abort
        send_list('{8'h90, 8'hF8, 8'h3C, 8'hFE, 8'h64});
        idle(2);
        send_list('{8'h80, 8'h3C, 8'h00});
        send_list('{8'h90, 8'h3C, 8'hF0, 8'h64});
        idle(2);

        // Back-to-back legato retrigger on the same note
        send_list('{8'h90, 8'h45, 8'h20, 8'h45, 8'h21, 8'h47, 8'h22});
        idle(2);

        // Reset mid-message; trailing data ignored until new status
        send_list('{8'h90, 8'h3C});
        apply_reset("midreset");
        send_list('{8'h64, 8'h3C, 8'h64});
        idle(2);
        send_list('{8'h90, 8'h3E, 8'h64});
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
